cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor built from GROUP-bit lookahead groups. It generalises the fixed 16-bit four-group ripple-of-CLA adder to any width, with registered group slices, a valid/ready handshake with backpressure, subtract mode and signed overflow. It is the accumulation adder feeding the approximate multiplier datapaths, and includes an optional carry-disregard approximation.

---
 rtl/cla_pipe_adder.sv | 174 +++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
//   Operands are split into GROUP-bit lookahead groups. Each pipeline stage
//   resolves GROUPS_PER_STAGE groups and forwards the remaining operand bits
//   and the carry into the next unresolved group.
//   Optional macro: CLA_PIPE_CARRY_DISREGARD_EN drops the carry-out of the
//   lowest APPROX_GROUPS groups (approximate mode).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready is combinational)
//   a, b, cin, sub      operands, carry/borrow-in, subtract select
//   out_valid/out_ready result handshake
//   sum, cout, ovf      result, carry-out of top group, signed overflow
module cla_pipe_adder #(
   parameter int unsigned WIDTH            = 32,
   parameter int unsigned GROUP            = 4,
   parameter int unsigned GROUPS_PER_STAGE = 2,
   parameter int unsigned APPROX_GROUPS    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int unsigned NG = WIDTH / GROUP;
   localparam int unsigned S  = NG / GROUPS_PER_STAGE;
   localparam int unsigned SW = GROUPS_PER_STAGE * GROUP;

   // Elaboration-time parameter sanity checks.
   if ((WIDTH % GROUP) != 0) begin : g_chk_width
      $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
   end
   if ((NG % GROUPS_PER_STAGE) != 0) begin : g_chk_stage
      $error("cla_pipe_adder: NG must be a multiple of GROUPS_PER_STAGE");
   end
   if (APPROX_GROUPS >= NG) begin : g_chk_approx
      $error("cla_pipe_adder: APPROX_GROUPS must be below NG");
   end

   // Full lookahead carries of one group: cv[i+1] as a flat sum of products.
   function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] p,
                                                  input logic [GROUP-1:0] g,
                                                  input logic             c);
      logic [GROUP:0] cv;
      logic           term;
      cv    = '0;
      cv[0] = c;
      for (int i = 0; i < int'(GROUP); i++) begin
         term = c;
         for (int j = 0; j <= i; j++) term &= p[j];
         cv[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int m = j + 1; m <= i; m++) term &= p[m];
            cv[i+1] |= term;
         end
      end
      return cv;
   endfunction

   // Global advance enable: the whole pipeline moves or freezes together.
   logic en;
   assign en       = ~out_valid | out_ready;
   assign in_ready = en;

   for (genvar k = 0; k < S; k++) begin : g_stage
      localparam int unsigned LO = k * SW;
      localparam int unsigned HI = LO + SW;
      localparam int unsigned G0 = k * GROUPS_PER_STAGE;

      logic [WIDTH-1:LO] a_in;
      logic [WIDTH-1:LO] b_in;
      logic              c_in;
      logic              v_in;
      logic [SW-1:0]     s_stage;
      logic              c_out;
      logic [HI-1:0]     s_nxt;
      logic [HI-1:0]     s_r;
      logic              c_r;
      logic              v_r;

      // Stage inputs: raw operands for stage 0, previous stage registers otherwise.
      if (k == 0) begin : g_src
         assign a_in  = a;
         assign b_in  = sub ? ~b : b;
         assign c_in  = sub ? ~cin : cin;
         assign v_in  = in_valid;
         assign s_nxt = s_stage;
      end else begin : g_src
         assign a_in  = g_stage[k-1].g_fwd.a_r;
         assign b_in  = g_stage[k-1].g_fwd.b_r;
         assign c_in  = g_stage[k-1].c_r;
         assign v_in  = g_stage[k-1].v_r;
         assign s_nxt = {s_stage, g_stage[k-1].s_r};
      end

      // Groups inside a stage chain by group carry-out.
      always_comb begin
         logic             c;
         logic [GROUP-1:0] p;
         logic [GROUP-1:0] g;
         logic [GROUP:0]   cv;
         c       = c_in;
         s_stage = '0;
         for (int unsigned gi = 0; gi < GROUPS_PER_STAGE; gi++) begin
            p  = a_in[LO + gi*GROUP +: GROUP] ^ b_in[LO + gi*GROUP +: GROUP];
            g  = a_in[LO + gi*GROUP +: GROUP] & b_in[LO + gi*GROUP +: GROUP];
            cv = cla_carries(p, g, c);
            s_stage[gi*GROUP +: GROUP] = p ^ cv[GROUP-1:0];
`ifdef CLA_PIPE_CARRY_DISREGARD_EN
            if (G0 + gi < APPROX_GROUPS) c = 1'b0;
            else                         c = cv[GROUP];
`else
            c = cv[GROUP];
`endif
         end
         c_out = c;
      end

      // Resolved sum bits, carry into next group and valid bit.
      always_ff @(posedge clk) begin
         if (rst) begin
            v_r <= 1'b0;
            c_r <= 1'b0;
            s_r <= '0;
         end else if (en) begin
            v_r <= v_in;
            c_r <= c_out;
            s_r <= s_nxt;
         end
      end

      // Unresolved operand bits travel alongside the partial result.
      if (k < S - 1) begin : g_fwd
         logic [WIDTH-1:HI] a_r;
         logic [WIDTH-1:HI] b_r;
         always_ff @(posedge clk) begin
            if (rst) begin
               a_r <= '0;
               b_r <= '0;
            end else if (en) begin
               a_r <= a_in[WIDTH-1:HI];
               b_r <= b_in[WIDTH-1:HI];
            end
         end
      end

      // Carry into the MSB is recovered as sum ^ a ^ b_e at the MSB.
      if (k == S - 1) begin : g_last
         logic ovf_r;
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_r <= 1'b0;
            end else if (en) begin
               ovf_r <= c_out ^ (s_stage[SW-1] ^ a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            end
         end
      end
   end

   assign out_valid = g_stage[S-1].v_r;
   assign sum       = g_stage[S-1].s_r;
   assign cout      = g_stage[S-1].c_r;
   assign ovf       = g_stage[S-1].g_last.ovf_r;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Testbench for cla_pipe_adder: directed 16-bit scenarios plus a randomized
// 32-bit regression against an arithmetic reference model.
module tb_cla_pipe_adder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // 16-bit exact instance and 16-bit approximate instance share inputs.
   logic        v16, ordy16, cin16, sub16;
   logic [15:0] a16, b16;
   logic        rdy16, ov16, cout16, ovf16;
   logic [15:0] sum16;
   logic        rdy16a, ov16a, cout16a, ovf16a;
   logic [15:0] sum16a;

   // 32-bit instance for the random regression.
   logic        v32, ordy32, cin32, sub32;
   logic [31:0] a32, b32;
   logic        rdy32, ov32, cout32, ovf32;
   logic [31:0] sum32;

   cla_pipe_adder #(.WIDTH(16), .GROUP(4), .GROUPS_PER_STAGE(1), .APPROX_GROUPS(0)) dut16 (
      .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16),
      .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(ordy16),
      .sum(sum16), .cout(cout16), .ovf(ovf16));

   cla_pipe_adder #(.WIDTH(16), .GROUP(4), .GROUPS_PER_STAGE(1), .APPROX_GROUPS(1)) dut16a (
      .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16a), .a(a16), .b(b16),
      .cin(cin16), .sub(sub16), .out_valid(ov16a), .out_ready(ordy16),
      .sum(sum16a), .cout(cout16a), .ovf(ovf16a));

   cla_pipe_adder #(.WIDTH(32), .GROUP(4), .GROUPS_PER_STAGE(2), .APPROX_GROUPS(0)) dut32 (
      .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .a(a32), .b(b32),
      .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(ordy32),
      .sum(sum32), .cout(cout32), .ovf(ovf32));

   typedef struct packed {
      logic        c;
      logic        o;
      logic [31:0] s;
   } res_t;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference: plain signed/unsigned arithmetic on wide integers.
   function automatic res_t ref_model(input logic [31:0] x, input logic [31:0] y,
                                      input logic c, input logic s);
      longint ux, uy, uc, r, sx, sy, sr;
      res_t   t;
      ux = longint'(x);
      uy = longint'(y);
      uc = longint'(c);
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (!s) begin
         r   = ux + uy + uc;
         sr  = sx + sy + uc;
         t.c = (r >= 64'sh1_0000_0000);
      end else begin
         r   = ux - uy - uc;
         sr  = sx - sy - uc;
         t.c = (ux >= uy + uc);
      end
      t.s = 32'(r);
      t.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return t;
   endfunction

   // One isolated operation on a 16-bit instance with latency measurement.
   task automatic single_op(input string tag, input bit apx,
                            input logic [15:0] xa, input logic [15:0] xb,
                            input logic xc, input logic xs,
                            input logic [15:0] es, input logic ec, input logic eo);
      int lat;
      @(negedge clk);
      ordy16 = 1'b1;
      v16 = 1'b1; a16 = xa; b16 = xb; cin16 = xc; sub16 = xs;
      #1;
      check({tag, "_rdy"}, apx ? rdy16a : rdy16, 1);
      @(negedge clk);
      v16 = 1'b0;
      lat = 1;
      while (!(apx ? ov16a : ov16) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 4);
      check({tag, "_sum"}, apx ? sum16a : sum16, es);
      check({tag, "_cout"}, apx ? cout16a : cout16, ec);
      check({tag, "_ovf"}, apx ? ovf16a : ovf16, eo);
   endtask

   int   i, n_got, bcyc, first_c, last_c, cnt;
   int   n_in, n_out, cyc;
   res_t q[$];
   res_t expv, hold_val;
   logic hold_pend;

   initial begin
      rst = 1'b1;
      v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; ordy16 = 1'b1;
      v32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; ordy32 = 1'b1;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_out_valid", ov16, 0);
      check("rst_in_ready", rdy16, 1);
      check("rst_sum", sum16, 0);
      check("rst_cout", cout16, 0);
      check("rst_ovf", ovf16, 0);
      check("rst_out_valid32", ov32, 0);
      rst = 1'b0;

      // Directed arithmetic
      single_op("add_wrap", 0, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
      single_op("add_ovf",  0, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
      single_op("sub_neg",  0, 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
      single_op("sub_bin",  0, 16'h000A, 16'h0003, 1, 1, 16'h0006, 1, 0);
      single_op("sub_ovf",  0, 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
      single_op("ex_lo",    0, 16'h000F, 16'h0001, 0, 0, 16'h0010, 0, 0);
`ifdef CLA_PIPE_CARRY_DISREGARD_EN
      single_op("apx_lo",   1, 16'h000F, 16'h0001, 0, 0, 16'h0000, 0, 0);
`else
      single_op("apx_lo",   1, 16'h000F, 16'h0001, 0, 0, 16'h0010, 0, 0);
`endif
      single_op("apx_hi",   1, 16'h00F0, 16'h0010, 0, 0, 16'h0100, 0, 0);

      // Backpressure: fill with out_ready low
      @(negedge clk);
      ordy16 = 1'b0;
      i = 1;
      for (int c = 0; c < 8; c++) begin
         v16 = (i <= 6); a16 = 16'(i); b16 = 16'(i); cin16 = 1'b0; sub16 = 1'b0;
         #1;
         if (v16 && rdy16) i++;
         @(negedge clk);
      end
      check("bp_accepted", 64'(i - 1), 4);
      check("bp_in_ready", rdy16, 0);
      check("bp_out_valid", ov16, 1);
      check("bp_sum", sum16, 16'h0002);
      repeat (3) begin
         @(negedge clk);
         check("bp_hold", {ov16, rdy16, sum16}, {1'b1, 1'b0, 16'h0002});
      end
      // Release and drain in order
      ordy16 = 1'b1;
      n_got = 0; bcyc = 0; first_c = 0; last_c = 0;
      while (n_got < 6 && bcyc < 30) begin
         v16 = (i <= 6); a16 = 16'(i); b16 = 16'(i);
         #1;
         if (ov16 && ordy16) begin
            n_got++;
            check("bp_order", sum16, 16'(2 * n_got));
            if (n_got == 1) first_c = bcyc;
            last_c = bcyc;
         end
         if (v16 && rdy16) i++;
         @(negedge clk);
         bcyc++;
      end
      v16 = 1'b0;
      check("bp_count", 64'(n_got), 6);
      check("bp_span", 64'(last_c - first_c), 5);
      @(negedge clk);
      check("bp_empty", ov16, 0);

      // Reset mid-flight
      ordy16 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         v16 = 1'b1; a16 = 16'(100 + c); b16 = 16'h0001;
         @(negedge clk);
      end
      v16 = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_out_valid", ov16, 0);
      check("mrst_in_ready", rdy16, 1);
      check("mrst_sum", sum16, 0);
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (ov16) cnt++;
      end
      check("mrst_no_stale", 64'(cnt), 0);

      // Random regression on the 32-bit instance
      n_in = 0; n_out = 0; cyc = 0; hold_pend = 1'b0; hold_val = '0;
      while (n_out < 10000 && cyc < 40000) begin
         if (hold_pend) check("rnd_hold", {ov32, cout32, ovf32, sum32}, {1'b1, hold_val});
         v32    = (n_in < 10000) && ($urandom_range(0, 9) < 8);
         a32    = $urandom;
         b32    = $urandom;
         cin32  = 1'($urandom_range(0, 1));
         sub32  = 1'($urandom_range(0, 1));
         ordy32 = ($urandom_range(0, 9) < 7);
         #1;
         hold_pend = ov32 && !ordy32;
         hold_val  = {cout32, ovf32, sum32};
         if (ov32 && ordy32) begin
            if (q.size() == 0) begin
               check("rnd_spurious", ov32, 0);
            end else begin
               expv = q.pop_front();
               check("rnd_res", {cout32, ovf32, sum32}, expv);
            end
            n_out++;
         end
         if (v32 && rdy32) begin
            q.push_back(ref_model(a32, b32, cin32, sub32));
            n_in++;
         end
         @(negedge clk);
         cyc++;
      end
      v32 = 1'b0;
      check("rnd_count", 64'(n_out), 10000);
      check("rnd_drain", 64'(q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
